mano_dr_isz: RTL

- Parametrised successor to the basic-computer data register (DR).
- Adds a generic WIDTH, a reset value, DEC and CLR operations, a registered wrap flag, a combinational zero flag, and a two-cycle increment-and-skip-if-zero (ISZ) sequence with a skip pulse.
- Sits on the common bus beside AC/IR.
- Driven by the control unit's decoded timing/opcode field.

---
 rtl/mano_dr_isz_if.sv | 33 +++
 rtl/mano_dr_isz.sv | 81 ++++++++
 2 files changed

// File: rtl/mano_dr_isz_if.sv
// Bus-side signal bundle for the parametrised data register.
// master: control unit / bus side; slave: the register itself.
interface mano_dr_isz_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] IN;
    logic [2:0]       OP;
    logic [WIDTH-1:0] Q_DR;
    logic             ZERO;
    logic             WRAP;
    logic             BUSY;
    logic             SKIP;

    modport master (
        output IN,
        output OP,
        input  Q_DR,
        input  ZERO,
        input  WRAP,
        input  BUSY,
        input  SKIP
    );

    modport slave (
        input  IN,
        input  OP,
        output Q_DR,
        output ZERO,
        output WRAP,
        output BUSY,
        output SKIP
    );
endinterface

// File: rtl/mano_dr_isz.sv
// Parametrised data register with LD/INC/DEC/CLR, wrap/zero flags and a
// two-cycle increment-and-skip-if-zero sequence.
module mano_dr_isz #(
    parameter int unsigned WIDTH   = 16,
    parameter logic [63:0] RST_VAL = 64'd0
) (
    input logic           CLK,
    input logic           RST_N,
    mano_dr_isz_if.slave  bus
);
    localparam logic [WIDTH-1:0] RstVal = RST_VAL[WIDTH-1:0];

    localparam logic IDLE  = 1'b0;
    localparam logic CHECK = 1'b1;

    localparam logic [2:0] OpHold = 3'b000;
    localparam logic [2:0] OpIsz  = 3'b001;
    localparam logic [2:0] OpLd   = 3'b100;
    localparam logic [2:0] OpInc  = 3'b101;
    localparam logic [2:0] OpDec  = 3'b110;
    localparam logic [2:0] OpClr  = 3'b111;

    logic [WIDTH-1:0] q_dr_q, q_dr_d;
    logic             wrap_q, wrap_d;
    logic             skip_q, skip_d;
    logic             state_q, state_d;

    always_comb begin
        q_dr_d  = q_dr_q;
        wrap_d  = wrap_q;
        skip_d  = 1'b0;
        state_d = state_q;
        if (state_q == CHECK) begin
            // Q_DR already holds the incremented value; OP is ignored here.
            skip_d  = (q_dr_q == '0);
            state_d = IDLE;
        end else begin
            case (bus.OP)
                OpLd: begin
                    q_dr_d = bus.IN;
                    wrap_d = 1'b0;
                end
                OpInc, OpIsz: begin
                    q_dr_d = q_dr_q + WIDTH'(1);
                    wrap_d = &q_dr_q;
                    if (bus.OP == OpIsz) state_d = CHECK;
                end
                OpDec: begin
                    q_dr_d = q_dr_q - WIDTH'(1);
                    wrap_d = (q_dr_q == '0);
                end
                OpClr: begin
                    q_dr_d = '0;
                    wrap_d = 1'b0;
                end
                OpHold: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            q_dr_q  <= RstVal;
            wrap_q  <= 1'b0;
            skip_q  <= 1'b0;
            state_q <= IDLE;
        end else begin
            q_dr_q  <= q_dr_d;
            wrap_q  <= wrap_d;
            skip_q  <= skip_d;
            state_q <= state_d;
        end
    end

    assign bus.Q_DR = q_dr_q;
    assign bus.ZERO = (q_dr_q == '0);
    assign bus.WRAP = wrap_q;
    assign bus.BUSY = (state_q == CHECK);
    assign bus.SKIP = skip_q;
endmodule
